// File: rtl/bs_pkg.sv
// Shared definitions for the barrel-shifter arbiter slice: default sizes and
// the requester-ID width helper.
package bs_pkg;

  localparam int unsigned DEF_N = 4;
  localparam int unsigned DEF_W = 32;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bs.sv
// Combinational barrel shifter: left/right, logical/arithmetic, shift/rotate.
module bs
  import bs_pkg::*;
#(
  parameter int unsigned W        = DEF_W,
  parameter int unsigned SHIFT_W  = $clog2(W),
  parameter logic        P_RIGHT  = 1'b0,
  parameter logic        P_ARITH  = 1'b0,
  parameter logic        P_ROTATE = 1'b0
) (
  input  logic [W-1:0]       x,
  input  logic [SHIFT_W-1:0] shift,
  output logic [W-1:0]       y_c
);

  generate
    if (P_ROTATE) begin : g_rot
      // Shifting a doubled copy gives the rotate in one half.
      logic [2*W-1:0] dbl;
      if (P_RIGHT) begin : g_right
        assign dbl = {x, x} >> shift;
        assign y_c = dbl[W-1:0];
      end else begin : g_left
        assign dbl = {x, x} << shift;
        assign y_c = dbl[2*W-1:W];
      end
    end else begin : g_shf
      if (P_RIGHT && P_ARITH) begin : g_sra
        assign y_c = $signed(x) >>> shift;
      end else if (P_RIGHT) begin : g_srl
        assign y_c = x >> shift;
      end else begin : g_sll
        assign y_c = x << shift;
      end
    end
  endgenerate

endmodule

// File: rtl/rr_arb.sv
// Generic round-robin arbiter; the search starts at ptr and ptr advances
// past the winner whenever a grant is consumed.
module rr_arb
  import bs_pkg::*;
#(
  parameter int unsigned N    = DEF_N,
  parameter int unsigned ID_W = id_width(N)
) (
  input  logic            clk,
  input  logic            arst,
  input  logic [N-1:0]    req,
  input  logic            en,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx
);

  logic [ID_W-1:0] ptr;
  logic            found;
  int unsigned     k;
  logic [ID_W-1:0] idx;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    idx     = '0;
    for (int unsigned off = 0; off < N; off++) begin
      k = 32'(ptr) + off;
      if (k >= N) k = k - N;
      idx = ID_W'(k);
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt     = '0;
        gnt[idx] = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + ID_W'(1);
    end
  end

endmodule

// File: rtl/bs_arb.sv
// Round-robin sequencer sharing one barrel shifter among N requesters, with
// a single registered result stage tagged by requester ID.
module bs_arb
  import bs_pkg::*;
#(
  parameter int unsigned N        = DEF_N,
  parameter int unsigned W        = DEF_W,
  parameter logic        P_RIGHT  = 1'b0,
  parameter logic        P_ARITH  = 1'b0,
  parameter logic        P_ROTATE = 1'b0,
  parameter int unsigned SHIFT_W  = $clog2(W),
  parameter int unsigned ID_W     = id_width(N)
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [N-1:0]         req_vld_i,
  input  logic [N*W-1:0]       req_x_i,
  input  logic [N*SHIFT_W-1:0] req_shift_i,
  output logic [N-1:0]         req_rdy_o,
  output logic                 rsp_vld_o,
  output logic [ID_W-1:0]      rsp_id_o,
  output logic [W-1:0]         rsp_y_o,
  input  logic                 rsp_rdy_i
);

  typedef struct packed {
    logic [W-1:0]       x;
    logic [SHIFT_W-1:0] shift;
  } req_t;

  logic            accept;
  logic            xfer;
  logic [N-1:0]    gnt;
  logic [ID_W-1:0] gnt_idx;
  req_t            cur;
  logic [W-1:0]    y_c;

  // Output stage can load when empty or draining this cycle.
  assign accept    = !arst && (!rsp_vld_o || rsp_rdy_i);
  assign req_rdy_o = accept ? gnt : '0;
  assign xfer      = |req_rdy_o;

  rr_arb #(.N(N), .ID_W(ID_W)) u_rr (
    .clk     (clk),
    .arst    (arst),
    .req     (req_vld_i),
    .en      (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    cur = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        cur.x     = req_x_i[i*W +: W];
        cur.shift = req_shift_i[i*SHIFT_W +: SHIFT_W];
      end
    end
  end

  bs #(
    .W(W), .SHIFT_W(SHIFT_W),
    .P_RIGHT(P_RIGHT), .P_ARITH(P_ARITH), .P_ROTATE(P_ROTATE)
  ) u_bs (
    .x     (cur.x),
    .shift (cur.shift),
    .y_c   (y_c)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rsp_vld_o <= 1'b0;
      rsp_id_o  <= '0;
      rsp_y_o   <= '0;
    end else if (xfer) begin
      rsp_vld_o <= 1'b1;
      rsp_id_o  <= gnt_idx;
      rsp_y_o   <= y_c;
    end else if (rsp_rdy_i) begin
      rsp_vld_o <= 1'b0;
    end
  end

  a_rdy_onehot0 : assert property (@(posedge clk) disable iff (arst)
    $onehot0(req_rdy_o));

  a_rsp_stable : assert property (@(posedge clk) disable iff (arst)
    rsp_vld_o && !rsp_rdy_i |=> rsp_vld_o && $stable(rsp_id_o) && $stable(rsp_y_o));

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_req_chk
      a_req_stable : assert property (@(posedge clk) disable iff (arst)
        req_vld_i[gi] && !req_rdy_o[gi] |=>
          $stable(req_x_i[gi*W +: W]) && $stable(req_shift_i[gi*SHIFT_W +: SHIFT_W]));
    end
  endgenerate

endmodule

// File: tb/tb_bs_arb.sv
// Directed scoreboard bench for bs_arb: a left-shift instance for the main
// sequence and a rotate instance for the rotate boundaries.
module tb_bs_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             arst;
  logic [3:0]       vld;
  logic [3:0][31:0] xs;
  logic [3:0][4:0]  sh;
  logic [3:0]       rdy;
  logic             rsp_vld;
  logic [1:0]       rsp_id;
  logic [31:0]      rsp_y;
  logic             rsp_rdy;

  logic [3:0]       vld2;
  logic [3:0][31:0] xs2;
  logic [3:0][4:0]  sh2;
  logic [3:0]       rdy2;
  logic             rsp_vld2;
  logic [1:0]       rsp_id2;
  logic [31:0]      rsp_y2;
  logic             rsp_rdy2;

  bs_arb #(.N(4), .W(32)) dut (
    .clk(clk), .arst(arst), .req_vld_i(vld), .req_x_i(xs), .req_shift_i(sh),
    .req_rdy_o(rdy), .rsp_vld_o(rsp_vld), .rsp_id_o(rsp_id), .rsp_y_o(rsp_y),
    .rsp_rdy_i(rsp_rdy)
  );

  bs_arb #(.N(4), .W(32), .P_ROTATE(1'b1)) dut_rot (
    .clk(clk), .arst(arst), .req_vld_i(vld2), .req_x_i(xs2), .req_shift_i(sh2),
    .req_rdy_o(rdy2), .rsp_vld_o(rsp_vld2), .rsp_id_o(rsp_id2), .rsp_y_o(rsp_y2),
    .rsp_rdy_i(rsp_rdy2)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] y;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [1:0]  m_ptr;
  logic        m_vld;
  logic [1:0]  m_id;
  logic [31:0] m_y;
  logic [1:0]  order [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [3:0] v,
                                         output logic hit);
    logic [1:0] k;
    hit = 1'b0;
    rr_pick = 2'd0;
    for (int o = 0; o < 4; o++) begin
      k = p + 2'(o);
      if (!hit && v[k]) begin
        hit = 1'b1;
        rr_pick = k;
      end
    end
  endfunction

  task automatic model_reset();
    m_ptr = 2'd0;
    m_vld = 1'b0;
    m_id  = 2'd0;
    m_y   = 32'd0;
    sb.delete();
  endtask

  // One clock: check combinational grant, push expectation, check result after the edge.
  task automatic cyc();
    logic       acc, hit, xf, drain;
    logic [1:0] g;
    logic [3:0] er;
    exp_t       e;
    #1;
    acc = !m_vld || rsp_rdy;
    g   = rr_pick(m_ptr, vld, hit);
    xf  = acc && hit;
    er  = xf ? (4'b0001 << g) : 4'b0000;
    chk("req_rdy", 64'(rdy), 64'(er));
    drain = rsp_rdy;
    if (xf) begin
      sb.push_back('{id: g, y: xs[g] << sh[g]});
      m_ptr = g + 2'd1;
    end
    @(posedge clk);
    #1;
    if (xf) begin
      e = sb.pop_front();
      m_vld = 1'b1;
      m_id  = e.id;
      m_y   = e.y;
    end else if (drain) begin
      m_vld = 1'b0;
    end
    chk("rsp_vld", 64'(rsp_vld), 64'(m_vld));
    if (m_vld) begin
      chk("rsp_id", 64'(rsp_id), 64'(m_id));
      chk("rsp_y", 64'(rsp_y), 64'(m_y));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    arst = 1'b1; vld = 4'hF; rsp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      xs[i] = 32'(i + 1); sh[i] = 5'(i);
      xs2[i] = 32'd0; sh2[i] = 5'd0;
    end
    vld2 = 4'h0; rsp_rdy2 = 1'b1;
    #7;
    chk("reset_rdy", 64'(rdy), 64'h0);
    chk("reset_vld", 64'(rsp_vld), 64'h0);
    chk("reset_id", 64'(rsp_id), 64'h0);
    chk("reset_y", 64'(rsp_y), 64'h0);
    vld = 4'h0;
    arst = 1'b0;
    model_reset();

    // Single request.
    xs[0] = 32'h0000_0001; sh[0] = 5'd4; vld = 4'b0001;
    cyc();
    chk("single_y", 64'(rsp_y), 64'h10);
    vld = 4'b0000;
    cyc();

    // Full contention from reset.
    arst = 1'b1; #1; arst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      xs[i] = 32'h11 * 32'(i + 1); sh[i] = 5'(i + 3);
    end
    vld = 4'hF;
    for (int n = 0; n < 6; n++) begin
      cyc();
      chk("order", 64'(rsp_id), 64'(order[n]));
    end

    // Backpressure holds the pending result.
    rsp_rdy = 1'b0;
    for (int n = 0; n < 5; n++) cyc();
    chk("bp_id", 64'(rsp_id), 64'd1);
    rsp_rdy = 1'b1;
    cyc();
    chk("bp_next", 64'(rsp_id), 64'd2);
    cyc();
    chk("bp_next2", 64'(rsp_id), 64'd3);

    // Pointer wrap: grant 2 then 3 before 0.
    cyc(); cyc(); cyc();
    chk("wrap_pre", 64'(rsp_id), 64'd2);
    vld = 4'b1001;
    cyc();
    chk("wrap_3", 64'(rsp_id), 64'd3);
    cyc();
    chk("wrap_0", 64'(rsp_id), 64'd0);

    // Shift boundaries.
    vld = 4'b0000;
    cyc();
    xs[0] = 32'hFFFF_FFFF; sh[0] = 5'd31; vld = 4'b0001;
    cyc();
    chk("sh31", 64'(rsp_y), 64'h8000_0000);
    sh[0] = 5'd0;
    cyc();
    chk("sh0", 64'(rsp_y), 64'hFFFF_FFFF);
    vld = 4'b0000;
    cyc();

    // Reset while a result is pending.
    vld = 4'hF;
    cyc();
    arst = 1'b1;
    #1;
    chk("mid_rst_vld", 64'(rsp_vld), 64'h0);
    chk("mid_rst_rdy", 64'(rdy), 64'h0);
    arst = 1'b0;
    model_reset();
    cyc();
    chk("post_rst_id", 64'(rsp_id), 64'd0);
    vld = 4'h0;
    cyc();

    // Rotate instance.
    xs2[0] = 32'h8000_0001; sh2[0] = 5'd1; vld2 = 4'b0001;
    #1;
    chk("rot_rdy", 64'(rdy2), 64'b0001);
    @(posedge clk); #1;
    vld2 = 4'b0000;
    chk("rot_vld", 64'(rsp_vld2), 64'd1);
    chk("rot_y1", 64'(rsp_y2), 64'h0000_0003);
    xs2[1] = 32'h8000_0001; sh2[1] = 5'd31; vld2 = 4'b0010;
    #1;
    chk("rot_rdy1", 64'(rdy2), 64'b0010);
    @(posedge clk); #1;
    vld2 = 4'b0000;
    chk("rot_id", 64'(rsp_id2), 64'd1);
    chk("rot_y31", 64'(rsp_y2), 64'hC000_0000);
    @(posedge clk); #1;
    chk("rot_drain", 64'(rsp_vld2), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
